cbp_pipelined_adder: RTL and testbench

- Parametrised, pipelined carry-bypass adder/subtractor; successor to the single-stage bypass adder block.
- Operand width is split into PIPE_STAGES equal slices; each slice is a chain of BLOCK_BITS-wide carry-bypass groups.
- Registered carry between slices; valid/ready handshake with back-pressure.
- Sits in the datapath between operand registers and accumulator/ALU consumers.

---
 rtl/cbp_pipelined_adder_if.sv | 36 +++
 rtl/cbp_pipelined_adder.sv | 147 ++++++++++++++
 tb/tb_cbp_pipelined_adder.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cbp_pipelined_adder_if.sv
// ---------------------------------------------------------------------------
// cbp_pipelined_adder_if
//   Operand / result handshake bundle for cbp_pipelined_adder.
//
//   Input side : in_valid, in_ready, in_a, in_b, in_sub, in_cin
//   Output side: out_valid, out_ready, out_sum, out_cout, out_ovf
//
//   Modports:
//     master - the environment: drives operands, consumes results
//     slave  - the adder itself
// ---------------------------------------------------------------------------
interface cbp_pipelined_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_sub;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_sub, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sub, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );
endinterface

// File: rtl/cbp_pipelined_adder.sv
// ---------------------------------------------------------------------------
// cbp_pipelined_adder
//   Pipelined carry-bypass adder/subtractor with valid/ready back-pressure.
//   The operand width is cut into PIPE_STAGES equal slices; stage k adds
//   slice k (a chain of BLOCK_BITS-wide carry-bypass groups) and registers
//   the result together with the slice carry-out, which feeds stage k+1.
//   Latency is PIPE_STAGES accepted-transaction cycles.
//
//   Ports:
//     clk   - rising-edge clock
//     rst_n - asynchronous active-low reset
//     bus   - cbp_pipelined_adder_if.slave (operand and result handshakes)
//
//   Parameters:
//     WIDTH       - operand/result width, = PIPE_STAGES * SLICE
//     BLOCK_BITS  - bits per carry-bypass group; must divide SLICE
//     PIPE_STAGES - register stages (= latency)
//
//   Optional build macro:
//     CBP_SATURATE_EN - clamp out_sum to the signed limit when out_ovf = 1
// ---------------------------------------------------------------------------
module cbp_pipelined_adder #(
  parameter int WIDTH       = 32,
  parameter int BLOCK_BITS  = 4,
  parameter int PIPE_STAGES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  cbp_pipelined_adder_if.slave   bus
);

  localparam int SLICE  = WIDTH / PIPE_STAGES;
  localparam int GROUPS = SLICE / BLOCK_BITS;

  // Per-stage pipeline state. Full operands travel down the pipe: the upper
  // slices are still to be added, and the MSBs are needed for overflow.
  typedef struct packed {
    logic             valid;
    logic             carry;   // carry out of the highest slice added so far
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;       // already inverted for subtraction
    logic [WIDTH-1:0] sum;     // valid up to and including this stage's slice
  } stage_t;

  // One slice: ripple inside each group, bypass mux on the group carry-out.
  // When every bit of a group propagates, the incoming carry skips the
  // ripple chain; the ripple result would be identical, only slower.
  function automatic logic [SLICE:0] bypass_add(
    input logic [SLICE-1:0] a,
    input logic [SLICE-1:0] b,
    input logic             cin
  );
    logic [SLICE-1:0] s;
    logic             group_cin;
    logic             c;
    logic             p;
    logic             p_all;
    s         = '0;
    group_cin = cin;
    for (int g = 0; g < GROUPS; g++) begin
      c     = group_cin;
      p_all = 1'b1;
      for (int i = 0; i < BLOCK_BITS; i++) begin
        p = a[g*BLOCK_BITS+i] ^ b[g*BLOCK_BITS+i];
        s[g*BLOCK_BITS+i] = p ^ c;
        c     = (a[g*BLOCK_BITS+i] & b[g*BLOCK_BITS+i]) | (p & c);
        p_all = p_all & p;
      end
      group_cin = p_all ? group_cin : c;
    end
    return {group_cin, s};
  endfunction

  stage_t           stage_q   [PIPE_STAGES];
  stage_t           stage_d   [PIPE_STAGES];
  stage_t           feed      [PIPE_STAGES];
  logic [SLICE:0]   slice_res [PIPE_STAGES];
  logic             adv;
  stage_t           last;
  logic             ovf;

  // The whole pipe moves together or not at all; bubbles are kept.
  assign adv          = ~last.valid | bus.out_ready;
  assign bus.in_ready = adv;

  // NOTE: every variable assigned in an always_comb gets a value on every
  // path (here by full assignment before any partial update), so no latch
  // is inferred.
  always_comb begin
    feed[0].valid = bus.in_valid;
    feed[0].carry = bus.in_sub | bus.in_cin;
    feed[0].a     = bus.in_a;
    feed[0].b     = bus.in_sub ? ~bus.in_b : bus.in_b;
    feed[0].sum   = '0;
    for (int k = 1; k < PIPE_STAGES; k++) begin
      feed[k] = stage_q[k-1];
    end
    for (int k = 0; k < PIPE_STAGES; k++) begin
      slice_res[k] = bypass_add(feed[k].a[k*SLICE +: SLICE],
                                feed[k].b[k*SLICE +: SLICE],
                                feed[k].carry);
      stage_d[k]                     = feed[k];
      stage_d[k].sum[k*SLICE +: SLICE] = slice_res[k][SLICE-1:0];
      stage_d[k].carry               = slice_res[k][SLICE];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples its predecessor's pre-edge value. The datapath is reset too,
  // not just the valid bits, because the result must read zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < PIPE_STAGES; k++) begin
        stage_q[k] <= '0;
      end
    end else if (adv) begin
      for (int k = 0; k < PIPE_STAGES; k++) begin
        stage_q[k] <= stage_d[k];
      end
    end
  end

  assign last = stage_q[PIPE_STAGES-1];

  // Same-sign operands with a result of the other sign.
  assign ovf = (last.a[WIDTH-1] == last.b[WIDTH-1]) &
               (last.sum[WIDTH-1] != last.a[WIDTH-1]);

  assign bus.out_valid = last.valid;
  assign bus.out_cout  = last.carry;
  assign bus.out_ovf   = ovf;

`ifdef CBP_SATURATE_EN
  // On overflow the operand sign tells the direction: positive operands
  // overflowed upward, negative ones downward.
  always_comb begin
    bus.out_sum = last.sum;
    if (ovf) begin
      bus.out_sum = last.a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                    : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign bus.out_sum = last.sum;
`endif

endmodule

// File: tb/tb_cbp_pipelined_adder.sv
// ---------------------------------------------------------------------------
// tb_cbp_pipelined_adder
//   Directed self-checking bench for cbp_pipelined_adder (32-bit, 4 stages,
//   4-bit groups). Expected values are hand-computed constants; sums that
//   depend on CBP_SATURATE_EN carry both variants.
// ---------------------------------------------------------------------------
module tb_cbp_pipelined_adder;

  localparam int WIDTH   = 32;
  localparam int LATENCY = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  cbp_pipelined_adder_if #(.WIDTH(WIDTH)) bus ();

  cbp_pipelined_adder #(
    .WIDTH      (WIDTH),
    .BLOCK_BITS (4),
    .PIPE_STAGES(LATENCY)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stream vectors: a, b, sub, cin, raw sum, saturated sum, cout, ovf.
  logic [31:0] v_a    [8] = '{32'h0000_000F, 32'h1234_5678, 32'hFFFF_FFFF, 32'h0000_0010,
                              32'h0F0F_0F0F, 32'h8000_0000, 32'hAAAA_AAAA, 32'h0000_0000};
  logic [31:0] v_b    [8] = '{32'h0000_0001, 32'h1111_1111, 32'h0000_0002, 32'h0000_0001,
                              32'hF0F0_F0F0, 32'h0000_0001, 32'h5555_5555, 32'h0000_0000};
  logic        v_sub  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic        v_cin  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [31:0] v_raw  [8] = '{32'h0000_0010, 32'h2345_6789, 32'h0000_0001, 32'h0000_000F,
                              32'h0000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
  logic [31:0] v_sat  [8] = '{32'h0000_0010, 32'h2345_6789, 32'h0000_0001, 32'h0000_000F,
                              32'h0000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
  logic        v_cout [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  logic        v_ovf  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  function automatic logic [31:0] pick(input logic [31:0] raw, input logic [31:0] sat);
`ifdef CBP_SATURATE_EN
    return sat;
`else
    return raw;
`endif
  endfunction

  // Drives one beat with out_ready high and waits (bounded) for its result.
  task automatic send_one(input logic [31:0] a, input logic [31:0] b,
                          input logic sub, input logic cin,
                          output int lat, output logic rdy_ok,
                          output logic [31:0] sum, output logic cout, output logic ovf);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_sub    = sub;
    bus.in_cin    = cin;
    #1;
    rdy_ok = bus.in_ready;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 12) begin
      rdy_ok = rdy_ok & bus.in_ready;
      @(posedge clk); #1;
      lat++;
    end
    sum  = bus.out_sum;
    cout = bus.out_cout;
    ovf  = bus.out_ovf;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_sub    = 1'b0;
    bus.in_cin    = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid);
    end
    checks++;
    if (bus.out_sum !== 32'h0) begin
      failures++; $display("FAIL reset_out_sum got=%h want=00000000", bus.out_sum);
    end
    checks++;
    if (bus.out_cout !== 1'b0) begin
      failures++; $display("FAIL reset_out_cout got=%b want=0", bus.out_cout);
    end
    checks++;
    if (bus.out_ovf !== 1'b0) begin
      failures++; $display("FAIL reset_out_ovf got=%b want=0", bus.out_ovf);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready);
    end
    @(posedge clk); #1;
  endtask

  // Runs one directed vector and compares latency, ready and results.
  task automatic test_single(input string name, input logic [31:0] a, input logic [31:0] b,
                             input logic sub, input logic cin, input logic [31:0] e_sum,
                             input logic e_cout, input logic e_ovf);
    int          lat;
    logic        rdy_ok;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    send_one(a, b, sub, cin, lat, rdy_ok, sum, cout, ovf);
    checks++;
    if (lat != LATENCY) begin
      failures++; $display("FAIL %s_latency got=%0d want=%0d", name, lat, LATENCY);
    end
    checks++;
    if (rdy_ok !== 1'b1) begin
      failures++; $display("FAIL %s_in_ready got=%b want=1", name, rdy_ok);
    end
    checks++;
    if (sum !== e_sum) begin
      failures++; $display("FAIL %s_sum got=%h want=%h", name, sum, e_sum);
    end
    checks++;
    if (cout !== e_cout) begin
      failures++; $display("FAIL %s_cout got=%b want=%b", name, cout, e_cout);
    end
    checks++;
    if (ovf !== e_ovf) begin
      failures++; $display("FAIL %s_ovf got=%b want=%b", name, ovf, e_ovf);
    end
  endtask

  task automatic test_add();
    test_single("add_1p1", 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0002, 1'b0, 1'b0);
    test_single("bypass_chain", 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
  endtask

  task automatic test_sub();
    test_single("sub_5m7", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0);
  endtask

  task automatic test_overflow();
    test_single("ovf_pos", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0,
                pick(32'h8000_0000, 32'h7FFF_FFFF), 1'b0, 1'b1);
  endtask

  // 8 beats back to back; out_ready drops for 3 cycles once the pipe is full.
  task automatic test_back_to_back();
    int          sent;
    int          recv;
    logic        held_v;
    logic [31:0] held_sum;
    logic        held_cout;
    logic        held_ovf;
    sent   = 0;
    recv   = 0;
    held_v = 1'b0;
    for (int cyc = 0; cyc < 60 && recv < 8; cyc++) begin
      bus.out_ready = !(cyc >= 6 && cyc <= 8);
      bus.in_valid  = (sent < 8);
      if (sent < 8) begin
        bus.in_a   = v_a[sent];
        bus.in_b   = v_b[sent];
        bus.in_sub = v_sub[sent];
        bus.in_cin = v_cin[sent];
      end
      #1;
      if (held_v) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_sum !== held_sum ||
            bus.out_cout !== held_cout || bus.out_ovf !== held_ovf) begin
          failures++;
          $display("FAIL stall_stable cyc=%0d got=%b/%h/%b/%b want=1/%h/%b/%b", cyc,
                   bus.out_valid, bus.out_sum, bus.out_cout, bus.out_ovf,
                   held_sum, held_cout, held_ovf);
        end
      end
      held_v = 1'b0;
      if (bus.out_valid && !bus.out_ready) begin
        checks++;
        if (bus.in_ready !== 1'b0) begin
          failures++; $display("FAIL stall_in_ready cyc=%0d got=%b want=0", cyc, bus.in_ready);
        end
        held_v    = 1'b1;
        held_sum  = bus.out_sum;
        held_cout = bus.out_cout;
        held_ovf  = bus.out_ovf;
      end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (bus.out_sum !== pick(v_raw[recv], v_sat[recv]) ||
            bus.out_cout !== v_cout[recv] || bus.out_ovf !== v_ovf[recv]) begin
          failures++;
          $display("FAIL stream_beat%0d got=%h/%b/%b want=%h/%b/%b", recv,
                   bus.out_sum, bus.out_cout, bus.out_ovf,
                   pick(v_raw[recv], v_sat[recv]), v_cout[recv], v_ovf[recv]);
        end
        recv++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    checks++;
    if (recv != 8) begin
      failures++; $display("FAIL stream_count got=%0d want=8", recv);
    end
    repeat (2) @(posedge clk); #1;
  endtask

  // Three beats in flight, then an asynchronous reset pulse mid-cycle.
  task automatic test_reset_midflight();
    int seen;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_a     = 32'h0000_1000 + i;
      bus.in_b     = 32'h0000_0001;
      bus.in_sub   = 1'b0;
      bus.in_cin   = 1'b0;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL midreset_out_valid got=%b want=0", bus.out_valid);
    end
    checks++;
    if (bus.out_sum !== 32'h0) begin
      failures++; $display("FAIL midreset_out_sum got=%h want=00000000", bus.out_sum);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++; $display("FAIL midreset_stale got=%0d beats want=0", seen);
    end
    test_single("post_reset", 32'h0000_0100, 32'h0000_0023, 1'b0, 1'b1, 32'h0000_0124, 1'b0, 1'b0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_add();
    test_sub();
    test_overflow();
    test_back_to_back();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
